mem_qspi_flash_responder: RTL and testbench

- Synthesizable QSPI NOR-flash responder: the memory end of the link driven by mem_spi_controller.
- Oversamples sclk/cs_n/io on the system clock, decodes the command subset used by mem_transaction_fsm, and serves a small internal byte array.
- Used as the bench and FPGA loopback target for the memory interface.

---
 rtl/mem_qspi_flash_responder.sv | 264 ++++++++++++++++++++++++++
 tb/tb_mem_qspi_flash_responder.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_qspi_flash_responder.sv
// QSPI NOR-flash responder: the memory end of the link. Oversamples sclk,
// cs_n and io_in on the system clock, decodes a small command subset
// (WREN, WRDI, RDSR1/2, WRSR2, READ, QUAD READ, PAGE PROGRAM) and serves
// a 2**ADDR_BITS byte register array.
module mem_qspi_flash_responder #(
    parameter int ADDR_BITS = 8,
    parameter bit QE_RESET  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic [3:0] io_in,
    output logic [3:0] io_out,
    output logic [3:0] io_oe,
    output logic       status_wel,
    output logic       status_qe
);

    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD1, S_RDQ, S_SR_OUT, S_PP, S_WSR, S_IGNORE
    } state_t;

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic                 sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic                 cs_meta_q, cs_sync_q;
    logic [3:0]           io_meta_q, io_sync_q;
    state_t               state_q, state_d;
    logic [4:0]           bit_cnt_q, bit_cnt_d;
    logic [2:0]           out_cnt_q, out_cnt_d;
    logic [23:0]          shift_q, shift_d;
    logic [7:0]           tx_q, tx_d;
    logic [7:0]           opcode_q, opcode_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic                 sr_sel_q, sr_sel_d;
    logic                 wel_q, wel_d;
    logic                 qe_q, qe_d;
    logic                 wel_clr_q, wel_clr_d;
    logic [3:0]           io_out_q, io_out_d;
    logic [7:0]           mem_q [DEPTH];

    logic        sclk_rise, sclk_fall, cs_active, mem_we;
    logic [23:0] shift_in;
    logic [7:0]  tx_byte;
    logic        io_hi_unused;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cs_active = ~cs_sync_q;
    assign shift_in  = {shift_q[22:0], io_sync_q[0]};
    // Only IO0 carries inbound data for the supported commands.
    assign io_hi_unused = ^io_sync_q[3:1];

    // Byte to present next: live status register or the array at addr_q.
    assign tx_byte = (state_q == S_SR_OUT)
                   ? (sr_sel_q ? {6'b0, qe_q, 1'b0} : {6'b0, wel_q, 1'b0})
                   : mem_q[addr_q];

    // Two-flop synchronisers plus previous-sclk flop for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            io_meta_q   <= 4'b0;
            io_sync_q   <= 4'b0;
        end else begin
            sclk_meta_q <= sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            cs_meta_q   <= cs_n;
            cs_sync_q   <= cs_meta_q;
            io_meta_q   <= io_in;
            io_sync_q   <= io_meta_q;
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 5'd0;
            out_cnt_q <= 3'd0;
            shift_q   <= 24'd0;
            tx_q      <= 8'd0;
            opcode_q  <= 8'd0;
            addr_q    <= '0;
            sr_sel_q  <= 1'b0;
            wel_q     <= 1'b0;
            qe_q      <= QE_RESET;
            wel_clr_q <= 1'b0;
            io_out_q  <= 4'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            out_cnt_q <= out_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            opcode_q  <= opcode_d;
            addr_q    <= addr_d;
            sr_sel_q  <= sr_sel_d;
            wel_q     <= wel_d;
            qe_q      <= qe_d;
            wel_clr_q <= wel_clr_d;
            io_out_q  <= io_out_d;
        end
    end

    // Array write port; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[addr_q] <= shift_in[7:0];
        end
    end

    // Next-state: command decode, bit shifting and output serialisation.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        out_cnt_d = out_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        opcode_d  = opcode_q;
        addr_d    = addr_q;
        sr_sel_d  = sr_sel_q;
        wel_d     = wel_q;
        qe_d      = qe_q;
        wel_clr_d = wel_clr_q;
        io_out_d  = io_out_q;
        mem_we    = 1'b0;

        if (!cs_active) begin
            // Deselect aborts everything; an accepted PP/WRSR consumes WEL here.
            if (state_q != S_IDLE && wel_clr_q) begin
                wel_d = 1'b0;
            end
            state_d   = S_IDLE;
            wel_clr_d = 1'b0;
            bit_cnt_d = 5'd0;
            out_cnt_d = 3'd0;
            io_out_d  = 4'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d   = S_CMD;
                    bit_cnt_d = 5'd0;
                    out_cnt_d = 3'd0;
                end
                S_CMD: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            opcode_d  = shift_in[7:0];
                            state_d   = S_IGNORE;
                            case (shift_in[7:0])
                                8'h06: wel_d = 1'b1;
                                8'h04: wel_d = 1'b0;
                                8'h05: begin sr_sel_d = 1'b0; state_d = S_SR_OUT; end
                                8'h35: begin sr_sel_d = 1'b1; state_d = S_SR_OUT; end
                                8'h31: if (wel_q) begin state_d = S_WSR; wel_clr_d = 1'b1; end
                                8'h03: state_d = S_ADDR;
                                8'h6B: if (qe_q) state_d = S_ADDR;
                                8'h02: if (wel_q) begin state_d = S_ADDR; wel_clr_d = 1'b1; end
                                default: state_d = S_IGNORE;
                            endcase
                        end
                    end
                end
                S_ADDR: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd23) begin
                            bit_cnt_d = 5'd0;
                            out_cnt_d = 3'd0;
                            addr_d    = shift_in[ADDR_BITS-1:0];
                            if (opcode_q == 8'h03)      state_d = S_RD1;
                            else if (opcode_q == 8'h6B) state_d = S_DUMMY;
                            else                        state_d = S_PP;
                        end
                    end
                end
                S_DUMMY: begin
                    if (sclk_rise) begin
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            state_d   = S_RDQ;
                        end
                    end
                end
                S_RD1, S_SR_OUT: begin
                    if (sclk_fall) begin
                        if (out_cnt_q == 3'd0) begin
                            io_out_d  = {2'b0, tx_byte[7], 1'b0};
                            tx_d      = {tx_byte[6:0], 1'b0};
                            out_cnt_d = 3'd7;
                            if (state_q == S_RD1) addr_d = addr_q + 1'b1;
                        end else begin
                            io_out_d  = {2'b0, tx_q[7], 1'b0};
                            tx_d      = {tx_q[6:0], 1'b0};
                            out_cnt_d = out_cnt_q - 3'd1;
                        end
                    end
                end
                S_RDQ: begin
                    if (sclk_fall) begin
                        if (out_cnt_q == 3'd0) begin
                            io_out_d  = tx_byte[7:4];
                            tx_d      = {tx_byte[3:0], 4'b0};
                            out_cnt_d = 3'd1;
                            addr_d    = addr_q + 1'b1;
                        end else begin
                            io_out_d  = tx_q[7:4];
                            out_cnt_d = 3'd0;
                        end
                    end
                end
                S_PP: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            mem_we    = 1'b1;
                            addr_d    = addr_q + 1'b1;
                        end
                    end
                end
                S_WSR: begin
                    if (sclk_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 5'd1;
                        if (bit_cnt_q == 5'd7) begin
                            bit_cnt_d = 5'd0;
                            qe_d      = shift_in[1];
                            state_d   = S_IGNORE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Drive enables straight from state, gated by the synchronised select.
    always_comb begin
        io_oe = 4'b0000;
        if (cs_active) begin
            if (state_q == S_RD1 || state_q == S_SR_OUT) io_oe = 4'b0010;
            else if (state_q == S_RDQ)                   io_oe = 4'b1111;
        end
    end

    assign io_out     = io_out_q;
    assign status_wel = wel_q;
    assign status_qe  = qe_q;

endmodule

// File: tb/tb_mem_qspi_flash_responder.sv
// Bench for mem_qspi_flash_responder: directed flash transactions followed
// by random ones, all checked against a byte-array/status-bit model.
module tb_mem_qspi_flash_responder;

    localparam int HALF = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       cs_n;
    logic [3:0] io_in;
    logic [3:0] io_out;
    logic [3:0] io_oe;
    logic       status_wel;
    logic       status_qe;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [256];
    logic       ref_wel;
    logic       ref_qe;

    mem_qspi_flash_responder #(.ADDR_BITS(8), .QE_RESET(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .cs_n       (cs_n),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .status_wel (status_wel),
        .status_qe  (status_qe)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One mode-0 sclk period: drive, hold low, sample outputs, rise, fall.
    task automatic sclk_cycle(input logic [3:0] drive, output logic [3:0] seen, output logic [3:0] oe);
        io_in = drive;
        repeat (HALF) @(posedge clk);
        #1;
        seen = io_out;
        oe   = io_oe;
        sclk = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        logic [3:0] o, e;
        for (int i = 7; i >= 0; i--) sclk_cycle({3'b0, b[i]}, o, e);
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic [3:0] oe);
        logic [3:0] o, e;
        for (int i = 7; i >= 0; i--) begin
            sclk_cycle(4'b0, o, e);
            b[i] = o[1];
            if (i == 7) oe = e;
        end
    endtask

    // 24-bit address; upper 16 bits random because the device ignores them.
    task automatic send_addr(input logic [7:0] a);
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_byte(a);
    endtask

    task automatic cs_end();
        repeat (HALF) @(posedge clk);
        #1;
        cs_n = 1'b1;
        repeat (2 * HALF) @(posedge clk);
        #1;
    endtask

    task automatic check_status(input string tag);
        check_val({tag, "_wel"}, 32'(status_wel), 32'(ref_wel));
        check_val({tag, "_qe"}, 32'(status_qe), 32'(ref_qe));
    endtask

    task automatic do_cmd(input logic [7:0] op);
        cs_n = 1'b0;
        send_byte(op);
        cs_end();
        if (op == 8'h06) ref_wel = 1'b1;
        if (op == 8'h04) ref_wel = 1'b0;
        $display("txn cmd op=%02h", op);
    endtask

    task automatic do_rdsr(input logic [7:0] op);
        logic [7:0] b0, b1, exp;
        logic [3:0] e0, e1;
        exp = (op == 8'h05) ? {6'b0, ref_wel, 1'b0} : {6'b0, ref_qe, 1'b0};
        cs_n = 1'b0;
        send_byte(op);
        recv_byte(b0, e0);
        recv_byte(b1, e1);
        cs_end();
        check_val("rdsr_byte", 32'(b0), 32'(exp));
        check_val("rdsr_repeat", 32'(b1), 32'(exp));
        check_val("rdsr_oe", 32'(e0), 32'h2);
        $display("txn rdsr op=%02h val=%02h", op, b0);
    endtask

    task automatic do_read(input logic [7:0] a, input int n);
        logic [7:0] b;
        logic [3:0] e;
        cs_n = 1'b0;
        send_byte(8'h03);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            recv_byte(b, e);
            check_val("read_byte", 32'(b), 32'(ref_mem[8'(a + k)]));
            if (k == 0) check_val("read_oe", 32'(e), 32'h2);
        end
        cs_end();
        $display("txn read a=%02h n=%0d", a, n);
    endtask

    task automatic do_pp(input logic [7:0] a, input int n, input logic [31:0] data);
        logic [7:0] b;
        cs_n = 1'b0;
        send_byte(8'h02);
        send_addr(a);
        for (int k = 0; k < n; k++) begin
            b = data[31 - 8 * k -: 8];
            send_byte(b);
            if (ref_wel) ref_mem[8'(a + k)] = b;
        end
        cs_end();
        ref_wel = 1'b0;
        $display("txn pp a=%02h n=%0d data=%08h", a, n, data);
    endtask

    task automatic do_wrsr(input logic [7:0] d);
        cs_n = 1'b0;
        send_byte(8'h31);
        send_byte(d);
        cs_end();
        if (ref_wel) ref_qe = d[1];
        ref_wel = 1'b0;
        $display("txn wrsr d=%02h", d);
    endtask

    task automatic do_quad(input logic [7:0] a, input int n);
        logic [3:0] hi, lo, e0, e1;
        cs_n = 1'b0;
        send_byte(8'h6B);
        send_addr(a);
        send_byte(8'h00);
        for (int k = 0; k < n; k++) begin
            sclk_cycle(4'b0, hi, e0);
            sclk_cycle(4'b0, lo, e1);
            if (ref_qe) begin
                check_val("quad_hi", 32'(hi), 32'(ref_mem[8'(a + k)][7:4]));
                check_val("quad_lo", 32'(lo), 32'(ref_mem[8'(a + k)][3:0]));
                if (k == 0) check_val("quad_oe", 32'(e0), 32'hF);
            end else if (k == 0) begin
                check_val("quad_off_oe", 32'(e0), 32'h0);
            end
        end
        cs_end();
        $display("txn quad a=%02h n=%0d qe=%0d", a, n, ref_qe);
    endtask

    initial begin
        logic [7:0] b;
        logic [3:0] o, e;

        rst_n = 1'b0;
        sclk  = 1'b0;
        cs_n  = 1'b1;
        io_in = 4'b0;
        ref_wel = 1'b0;
        ref_qe  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check_val("rst_oe", 32'(io_oe), 32'h0);
        check_val("rst_out", 32'(io_out), 32'h0);
        check_status("rst");
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        // Status register basics.
        do_rdsr(8'h05);
        do_cmd(8'h06);
        check_status("wren");
        do_rdsr(8'h05);

        // Fill the whole array so every later read has a known value.
        cs_n = 1'b0;
        send_byte(8'h02);
        send_addr(8'h00);
        for (int i = 0; i < 256; i++) begin
            b = (i == 8'h12) ? 8'hFF : 8'($urandom);
            send_byte(b);
            ref_mem[i] = b;
        end
        cs_end();
        ref_wel = 1'b0;
        check_status("preload");
        $display("txn preload 256 bytes");

        // Program then read back across into the preloaded FF.
        do_cmd(8'h06);
        do_pp(8'h10, 2, 32'hA55A_0000);
        check_status("pp");
        do_read(8'h10, 3);
        check_val("read_ff", 32'(ref_mem[8'h12]), 32'hFF);

        // Program without WREN is ignored.
        do_pp(8'h20, 1, 32'h1100_0000);
        do_read(8'h20, 1);
        check_status("pp_nowel");

        // Address wrap at the top of the array.
        do_cmd(8'h06);
        do_pp(8'hFF, 2, 32'h3CC3_0000);
        do_read(8'hFF, 2);

        // Quad read refused, then enable QE and read quad.
        do_quad(8'h10, 1);
        do_cmd(8'h06);
        do_wrsr(8'h02);
        check_status("wrsr");
        do_quad(8'h10, 2);

        // Partial program byte is dropped.
        do_cmd(8'h06);
        cs_n = 1'b0;
        send_byte(8'h02);
        send_addr(8'h40);
        send_byte(8'h3C);
        for (int i = 0; i < 4; i++) sclk_cycle(4'b0101 & {3'b0, 1'(i)}, o, e);
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("pp_abort_oe", 32'(io_oe), 32'h0);
        repeat (2 * HALF) @(posedge clk);
        #1;
        ref_mem[8'h40] = 8'h3C;
        ref_wel = 1'b0;
        check_status("pp_abort");
        $display("txn pp partial a=40");
        do_read(8'h40, 2);

        // Deselect during a read drops the drivers quickly.
        cs_n = 1'b0;
        send_byte(8'h03);
        send_addr(8'h11);
        recv_byte(b, e);
        check_val("rd_abort_byte", 32'(b), 32'(ref_mem[8'h11]));
        cs_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rd_abort_oe", 32'(io_oe), 32'h0);
        repeat (2 * HALF) @(posedge clk);
        #1;
        $display("txn read aborted a=11");

        // Reset in the middle of a single read.
        do_cmd(8'h06);
        cs_n = 1'b0;
        send_byte(8'h03);
        send_addr(8'h10);
        for (int i = 0; i < 3; i++) sclk_cycle(4'b0, o, e);
        check_val("rd1_oe_pre", 32'(io_oe), 32'h2);
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_oe", 32'(io_oe), 32'h0);
        check_val("mid_rst_wel", 32'(status_wel), 32'h0);
        cs_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ref_wel = 1'b0;
        ref_qe  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        $display("txn reset during read");
        do_read(8'h10, 2);

        // Random mix of transactions.
        for (int t = 0; t < 30; t++) begin
            case ($urandom_range(0, 6))
                0: do_cmd(8'h06);
                1: do_cmd(8'h04);
                2: do_rdsr(($urandom_range(0, 1) == 0) ? 8'h05 : 8'h35);
                3: do_read(8'($urandom), $urandom_range(1, 3));
                4: begin
                    if ($urandom_range(0, 3) != 0) do_cmd(8'h06);
                    do_pp(8'($urandom), $urandom_range(0, 3), $urandom);
                end
                5: do_quad(8'($urandom), $urandom_range(1, 3));
                default: begin
                    do_cmd(8'h06);
                    do_wrsr(8'($urandom));
                end
            endcase
            check_status("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
